// File: rtl/ghost_target_control.sv
// Per-ghost movement controller: picks a direction each step from the wall map
// and a mode-dependent target tile (player in CHASE, corner in SCATTER, LFSR in FRIGHT).
module ghost_target_control #(
    parameter int unsigned TILE         = 20,
    parameter int unsigned COLS         = 32,
    parameter int unsigned ROWS         = 24,
    parameter int unsigned START_X      = 20,
    parameter int unsigned START_Y      = 160,
    parameter logic [1:0]  START_DIR    = 2'd3,
    parameter int unsigned SCAT_COL     = 0,
    parameter int unsigned SCAT_ROW     = 0,
    parameter int unsigned SCAT_STEPS   = 7,
    parameter int unsigned CHASE_STEPS  = 20,
    parameter int unsigned FRIGHT_STEPS = 6,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    parameter int unsigned WIDTH        = COLS * TILE,
    parameter int unsigned HEIGHT       = ROWS * TILE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      step,
    input  logic                      frighten,
    input  logic [$clog2(WIDTH)-1:0]  player_x,
    input  logic [$clog2(WIDTH)-1:0]  player_y,
    input  logic [ROWS*COLS-1:0]      tilemap_walls,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic [1:0]                ghost_direction,
    output logic [1:0]                mode,
    output logic                      busy
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned NW = $clog2(ROWS * COLS);
    localparam int unsigned PW = 8;

    typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;
    typedef enum logic [1:0] {M_SCATTER = 2'd0, M_CHASE = 2'd1, M_FRIGHT = 2'd2} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_MOVE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    dir_t          dir_q;
    mode_t         mode_q, saved_mode_q;
    logic [PW-1:0] cnt_q, saved_cnt_q;
    logic          force_q;
    logic [7:0]    lfsr_q;

    mode_t         dec_mode_q;
    logic [CW-1:0] tgt_col_q;
    logic [RW-1:0] tgt_row_q;
    logic          dec_force_q;
    logic [1:0]    dec_start_q;
    dir_t          best_dir_q;
    logic [6:0]    best_metric_q;
    logic          best_valid_q, rev_open_q;

    logic          accept;
    mode_t         eff_mode, sv_mode, mode_d;
    logic [PW-1:0] eff_cnt, sv_cnt, cnt_d, cnt_inc, limit;
    logic          eff_force, force_d;

    dir_t          rev_dir, cand_dir, move_dir;
    logic          do_move, in_range, cand_open;
    logic [CW-1:0] n_col, dcol, player_col;
    logic [RW-1:0] n_row, drow, player_row;
    logic [NW-1:0] wall_idx;
    logic [1:0]    rot;
    logic [6:0]    metric;

    assign accept     = (state_q == S_IDLE) && step;
    assign rev_dir    = dir_t'(2'(dir_q ^ 2'b01));
    assign player_col = CW'(player_x / TILE);
    assign player_row = RW'(player_y / TILE);

    // frighten is folded in first so a coincident step already sees FRIGHT
    always_comb begin
        eff_mode  = mode_q;
        eff_cnt   = cnt_q;
        eff_force = force_q;
        sv_mode   = saved_mode_q;
        sv_cnt    = saved_cnt_q;
        if (frighten) begin
            if (mode_q != M_FRIGHT) begin
                sv_mode = mode_q;
                sv_cnt  = cnt_q;
            end
            eff_mode  = M_FRIGHT;
            eff_cnt   = '0;
            eff_force = 1'b1;
        end
        mode_d  = eff_mode;
        cnt_d   = eff_cnt;
        force_d = eff_force;
        cnt_inc = eff_cnt + PW'(1);
        case (eff_mode)
            M_SCATTER: limit = PW'(SCAT_STEPS);
            M_CHASE:   limit = PW'(CHASE_STEPS);
            default:   limit = PW'(FRIGHT_STEPS);
        endcase
        // The flag is handed to the decision at accept; it is used by that decision's move
        if (accept) begin
            force_d = 1'b0;
            if (cnt_inc == limit) begin
                case (eff_mode)
                    M_SCATTER: begin mode_d = M_CHASE;   cnt_d = '0; force_d = 1'b1; end
                    M_CHASE:   begin mode_d = M_SCATTER; cnt_d = '0; force_d = 1'b1; end
                    default:   begin mode_d = sv_mode;   cnt_d = sv_cnt; end
                endcase
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_comb begin
        cand_dir = DIR_UP;
        n_col    = col_q;
        n_row    = row_q;
        in_range = 1'b0;
        case (idx_q)
            2'd0: begin cand_dir = DIR_UP;    in_range = (row_q != '0);            n_row = row_q - RW'(1); end
            2'd1: begin cand_dir = DIR_LEFT;  in_range = (col_q != '0);            n_col = col_q - CW'(1); end
            2'd2: begin cand_dir = DIR_DOWN;  in_range = (row_q != RW'(ROWS - 1)); n_row = row_q + RW'(1); end
            default: begin cand_dir = DIR_RIGHT; in_range = (col_q != CW'(COLS - 1)); n_col = col_q + CW'(1); end
        endcase
        wall_idx  = in_range ? NW'(32'(n_row) * COLS + 32'(n_col)) : '0;
        cand_open = in_range && !tilemap_walls[wall_idx];
        dcol      = (n_col > tgt_col_q) ? n_col - tgt_col_q : tgt_col_q - n_col;
        drow      = (n_row > tgt_row_q) ? n_row - tgt_row_q : tgt_row_q - n_row;
        // FRIGHT ranks candidates by cyclic distance from the LFSR start index
        rot       = idx_q - dec_start_q;
        metric    = (dec_mode_q == M_FRIGHT) ? 7'(rot) : 7'(dcol) + 7'(drow);
    end

    always_comb begin
        do_move  = 1'b0;
        move_dir = best_dir_q;
        if (rev_open_q && (dec_force_q || !best_valid_q)) begin
            do_move  = 1'b1;
            move_dir = rev_dir;
        end else if (best_valid_q) begin
            do_move = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (step) state_d = S_EVAL;
            S_EVAL:  if (idx_q == 2'd3) state_d = S_MOVE;
            S_MOVE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q         <= '0;
            x_q           <= XW'(START_X);
            y_q           <= YW'(START_Y);
            col_q         <= CW'(START_X / TILE);
            row_q         <= RW'(START_Y / TILE);
            dir_q         <= dir_t'(START_DIR);
            mode_q        <= M_SCATTER;
            saved_mode_q  <= M_SCATTER;
            cnt_q         <= '0;
            saved_cnt_q   <= '0;
            force_q       <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            dec_mode_q    <= M_SCATTER;
            tgt_col_q     <= '0;
            tgt_row_q     <= '0;
            dec_force_q   <= 1'b0;
            dec_start_q   <= '0;
            best_dir_q    <= DIR_UP;
            best_metric_q <= '1;
            best_valid_q  <= 1'b0;
            rev_open_q    <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            force_q      <= force_d;
            saved_mode_q <= sv_mode;
            saved_cnt_q  <= sv_cnt;
            if (accept) begin
                lfsr_q        <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                dec_start_q   <= lfsr_q[1:0];
                dec_mode_q    <= eff_mode;
                dec_force_q   <= eff_force;
                tgt_col_q     <= (eff_mode == M_CHASE) ? player_col : CW'(SCAT_COL);
                tgt_row_q     <= (eff_mode == M_CHASE) ? player_row : RW'(SCAT_ROW);
                idx_q         <= '0;
                best_dir_q    <= DIR_UP;
                best_metric_q <= '1;
                best_valid_q  <= 1'b0;
                rev_open_q    <= 1'b0;
            end
            if (state_q == S_EVAL) begin
                idx_q <= idx_q + 2'd1;
                if (cand_open) begin
                    if (cand_dir == rev_dir) begin
                        rev_open_q <= 1'b1;
                    end else if (!best_valid_q || metric < best_metric_q) begin
                        best_valid_q  <= 1'b1;
                        best_metric_q <= metric;
                        best_dir_q    <= cand_dir;
                    end
                end
            end
            if (state_q == S_MOVE && do_move) begin
                dir_q <= move_dir;
                case (move_dir)
                    DIR_UP:    begin y_q <= y_q - YW'(TILE); row_q <= row_q - RW'(1); end
                    DIR_DOWN:  begin y_q <= y_q + YW'(TILE); row_q <= row_q + RW'(1); end
                    DIR_LEFT:  begin x_q <= x_q - XW'(TILE); col_q <= col_q - CW'(1); end
                    default:   begin x_q <= x_q + XW'(TILE); col_q <= col_q + CW'(1); end
                endcase
            end
        end
    end

    assign x               = x_q;
    assign y               = y_q;
    assign ghost_direction = dir_q;
    assign mode            = mode_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_ghost_target_control.sv
// Directed bench for ghost_target_control: single-step neighbour table plus
// multi-cycle sequences for mode phasing, FRIGHT walk and mid-decision reset.
module tb_ghost_target_control;

    localparam int unsigned COLS = 32;
    localparam int unsigned ROWS = 24;
    localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 step = 1'b0;
    logic                 frighten = 1'b0;
    logic [9:0]           player_x = '0;
    logic [9:0]           player_y = '0;
    logic [ROWS*COLS-1:0] walls = '0;
    logic [9:0]           x;
    logic [8:0]           y;
    logic [1:0]           ghost_direction;
    logic [1:0]           mode;
    logic                 busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ghost_target_control dut (
        .clk             (clk),
        .reset           (reset),
        .step            (step),
        .frighten        (frighten),
        .player_x        (player_x),
        .player_y        (player_y),
        .tilemap_walls   (walls),
        .x               (x),
        .y               (y),
        .ghost_direction (ghost_direction),
        .mode            (mode),
        .busy            (busy)
    );

    typedef struct {
        logic [3:0] mask;   // walls around tile (1,8): [0]up [1]left [2]down [3]right
        int         ex;
        int         ey;
        int         ed;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(output int bc);
        bc = 0;
        while (busy && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        if (bc >= 20) check("busy_timeout", bc, 5);
    endtask

    task automatic pulse_step(input logic fr, output int bc);
        @(negedge clk);
        step     = 1'b1;
        frighten = fr;
        @(negedge clk);
        step     = 1'b0;
        frighten = 1'b0;
        wait_idle(bc);
    endtask

    task automatic set_neigh(input logic [3:0] m);
        walls = '0;
        walls[7*COLS+1] = m[0];
        walls[8*COLS+0] = m[1];
        walls[9*COLS+1] = m[2];
        walls[8*COLS+2] = m[3];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   bc;
        int   tc[7];
        int   tr[7];

        vecs[0] = '{4'b0000, 20, 140, D_UP};
        vecs[1] = '{4'b0001, 20, 180, D_DOWN};
        vecs[2] = '{4'b0101, 40, 160, D_RIGHT};
        vecs[3] = '{4'b1101,  0, 160, D_LEFT};
        vecs[4] = '{4'b1111, 20, 160, D_RIGHT};
        vecs[5] = '{4'b1001, 20, 180, D_DOWN};
        vecs[6] = '{4'b1110, 20, 140, D_UP};

        // reset values while reset is held
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_x", int'(x), 20);
        check("rst_y", int'(y), 160);
        check("rst_dir", int'(ghost_direction), D_RIGHT);
        check("rst_mode", int'(mode), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        // single-step table from tile (1,8) heading right, SCATTER target (0,0)
        for (int i = 0; i < 7; i++) begin
            do_reset();
            set_neigh(vecs[i].mask);
            pulse_step(1'b0, bc);
            if (i == 0) check("busy_cycles", bc, 5);
            check($sformatf("vec%0d_x", i), int'(x), vecs[i].ex);
            check($sformatf("vec%0d_y", i), int'(y), vecs[i].ey);
            check($sformatf("vec%0d_dir", i), int'(ghost_direction), vecs[i].ed);
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
        end

        // frighten during EVAL: mode switches at once, decision stays SCATTER
        do_reset();
        walls = '0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step     = 1'b0;
        frighten = 1'b1;
        @(negedge clk);
        frighten = 1'b0;
        check("evalfr_mode", int'(mode), 2);
        check("evalfr_busy", int'(busy), 1);
        wait_idle(bc);
        check("evalfr_x", int'(x), 20);
        check("evalfr_y", int'(y), 140);
        check("evalfr_dir", int'(ghost_direction), D_UP);

        // frighten+step together: forced reverse, then LFSR-driven walk (seed A5)
        do_reset();
        walls = '0;
        pulse_step(1'b1, bc);
        check("fr1_x", int'(x), 0);
        check("fr1_dir", int'(ghost_direction), D_LEFT);
        check("fr1_mode", int'(mode), 2);
        pulse_step(1'b0, bc);
        check("fr2_y", int'(y), 180);
        check("fr2_dir", int'(ghost_direction), D_DOWN);
        pulse_step(1'b0, bc);
        check("fr3_y", int'(y), 200);
        check("fr3_x", int'(x), 0);

        // walk to (5,5) through FRIGHT (scatter count preserved), then open-corridor tie
        do_reset();
        @(negedge clk);
        frighten = 1'b1;
        @(negedge clk);
        frighten = 1'b0;
        check("nav_mode_fr", int'(mode), 2);
        tc = '{1, 1, 1, 2, 3, 4, 5};
        tr = '{7, 6, 5, 5, 5, 5, 5};
        for (int i = 0; i < 7; i++) begin
            walls = '1;
            walls[tr[i]*COLS+tc[i]] = 1'b0;
            pulse_step(1'b0, bc);
            if (i == 5) check("nav_mode_restored", int'(mode), 0);
        end
        check("nav_x", int'(x), 100);
        check("nav_y", int'(y), 100);
        check("nav_dir", int'(ghost_direction), D_RIGHT);
        walls = '0;
        pulse_step(1'b0, bc);
        check("tie_x", int'(x), 100);
        check("tie_y", int'(y), 80);
        check("tie_dir", int'(ghost_direction), D_UP);
        check("tie_mode", int'(mode), 0);

        // phase counting in a horizontal corridor on row 8, player at tile (30,8)
        do_reset();
        walls = '1;
        for (int c = 0; c < 32; c++) walls[8*COLS+c] = 1'b0;
        player_x = 10'd600;
        player_y = 10'd160;
        for (int i = 1; i <= 7; i++) begin
            pulse_step(1'b0, bc);
            if (i == 6) check("ph_mode_6", int'(mode), 0);
        end
        check("ph_x_7", int'(x), 160);
        check("ph_mode_7", int'(mode), 1);
        pulse_step(1'b0, bc);
        check("ph_rev_x", int'(x), 140);
        check("ph_rev_dir", int'(ghost_direction), D_LEFT);
        pulse_step(1'b0, bc);
        check("ph_norev_x", int'(x), 120);
        @(negedge clk);
        frighten = 1'b1;
        @(negedge clk);
        frighten = 1'b0;
        check("ph_fr_mode", int'(mode), 2);
        for (int i = 0; i < 6; i++) pulse_step(1'b0, bc);
        check("ph_fr_x", int'(x), 240);
        check("ph_fr_dir", int'(ghost_direction), D_RIGHT);
        check("ph_fr_done_mode", int'(mode), 1);
        for (int i = 0; i < 17; i++) pulse_step(1'b0, bc);
        check("ph_chase17_mode", int'(mode), 1);
        check("ph_chase17_x", int'(x), 580);
        pulse_step(1'b0, bc);
        check("ph_chase18_mode", int'(mode), 0);
        check("ph_chase18_x", int'(x), 600);

        // reset asserted mid-decision
        do_reset();
        walls = '0;
        pulse_step(1'b0, bc);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_x", int'(x), 20);
        check("midrst_y", int'(y), 160);
        check("midrst_dir", int'(ghost_direction), D_RIGHT);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_after_y", int'(y), 160);
        check("midrst_after_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
